// File: rtl/gbuff_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gbuff_arbiter
// Purpose  : Two-port round-robin front end for the single-port global_buffer.
//            Optional burst lock is built when GBUFF_ARB_BURST_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module gbuff_arbiter #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [ADDR_BITS-1:0] a_addr,
  input  logic [DATA_BITS-1:0] a_wdata,
  input  logic                 a_lock,
  output logic                 a_gnt,
  output logic                 a_rvalid,
  output logic [DATA_BITS-1:0] a_rdata,

  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [ADDR_BITS-1:0] b_addr,
  input  logic [DATA_BITS-1:0] b_wdata,
  input  logic                 b_lock,
  output logic                 b_gnt,
  output logic                 b_rvalid,
  output logic [DATA_BITS-1:0] b_rdata,

  output logic                 gb_wr_en,
  output logic [ADDR_BITS-1:0] gb_index,
  output logic [DATA_BITS-1:0] gb_data_in,
  input  logic [DATA_BITS-1:0] gb_data_out
);

  logic prio_q;
  logic prio_d;
  logic w_arb_a;
  logic w_arb_b;
  logic w_gnt_a;
  logic w_gnt_b;
  logic a_rvalid_q;
  logic a_rvalid_d;
  logic b_rvalid_q;
  logic b_rvalid_d;

  // prio_q = 1 means B wins when both ports request.
  assign w_arb_a = a_req & (~b_req | ~prio_q);
  assign w_arb_b = b_req & (~a_req |  prio_q);

`ifdef GBUFF_ARB_BURST_EN
  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_LOCK_A = 2'd1,
    ST_LOCK_B = 2'd2
  } state_t;

  localparam int                    c_cnt_bits  = $clog2(MAX_BURST + 1);
  localparam logic [c_cnt_bits-1:0] c_max_burst = c_cnt_bits'(MAX_BURST);

  state_t                  state_q;
  state_t                  state_d;
  logic [c_cnt_bits-1:0]   burst_cnt_q;
  logic [c_cnt_bits-1:0]   burst_cnt_d;
  logic [c_cnt_bits-1:0]   w_cnt_inc;

  assign w_cnt_inc = burst_cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ARB;
      burst_cnt_q <= '0;
      prio_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      prio_q      <= prio_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    prio_d      = prio_q;
    w_gnt_a     = 1'b0;
    w_gnt_b     = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_LOCK_A: begin
          w_gnt_a     = a_req;
          burst_cnt_d = w_cnt_inc;
          // Lock ends on release, on a gap, or when this grant fills the burst.
          if (!a_req || !a_lock || (w_cnt_inc == c_max_burst)) begin
            state_d     = ST_ARB;
            prio_d      = 1'b1;
            burst_cnt_d = '0;
          end
        end
        ST_LOCK_B: begin
          w_gnt_b     = b_req;
          burst_cnt_d = w_cnt_inc;
          if (!b_req || !b_lock || (w_cnt_inc == c_max_burst)) begin
            state_d     = ST_ARB;
            prio_d      = 1'b0;
            burst_cnt_d = '0;
          end
        end
        default: begin
          w_gnt_a = w_arb_a;
          w_gnt_b = w_arb_b;
          if (w_arb_a) begin
            prio_d = 1'b1;
            if (a_lock) begin
              state_d     = ST_LOCK_A;
              burst_cnt_d = c_cnt_bits'(1);
            end
          end else if (w_arb_b) begin
            prio_d = 1'b0;
            if (b_lock) begin
              state_d     = ST_LOCK_B;
              burst_cnt_d = c_cnt_bits'(1);
            end
          end
        end
      endcase
    end
  end
`else
  localparam int c_max_burst_unused = MAX_BURST;
  logic          w_lock_unused;

  assign w_lock_unused = a_lock ^ b_lock;

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

  always_comb begin
    prio_d  = prio_q;
    w_gnt_a = w_arb_a & ~rst;
    w_gnt_b = w_arb_b & ~rst;
    if (w_gnt_a) begin
      prio_d = 1'b1;
    end else if (w_gnt_b) begin
      prio_d = 1'b0;
    end
  end
`endif

  assign a_gnt = w_gnt_a;
  assign b_gnt = w_gnt_b;

  assign gb_wr_en   = (w_gnt_a & a_we) | (w_gnt_b & b_we);
  assign gb_index   = w_gnt_a ? a_addr  : (w_gnt_b ? b_addr  : '0);
  assign gb_data_in = w_gnt_a ? a_wdata : (w_gnt_b ? b_wdata : '0);

  assign a_rvalid_d = w_gnt_a & ~a_we;
  assign b_rvalid_d = w_gnt_b & ~b_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end

  // Masking with rst drops a read that was granted just before reset.
  assign a_rvalid = a_rvalid_q & ~rst;
  assign b_rvalid = b_rvalid_q & ~rst;
  assign a_rdata  = a_rvalid ? gb_data_out : '0;
  assign b_rdata  = b_rvalid ? gb_data_out : '0;

endmodule
`default_nettype wire
